// File: rtl/mod_reg16_1to16.sv
// -----------------------------------------------------------------------------
// mod_reg16_1to16
//
// Collects the byte stream that comes back from the S-box ROM and rebuilds it
// into one 128-bit AES state for the ShiftRows stage. The block drives the
// byte-request strobe of the upstream 16-to-1 serializer and captures each
// returned byte ROM_LAT cycles later. It has a single output buffer, so no new
// block is requested while an assembled block is still held.
//
// Parameters:
//   N        bytes per block; fixed at 16
//   ROM_LAT  cycles from req_rom high to the matching byte on rom_data (1..4)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   blk_valid  in   upstream holds a full block (looked at only while idle)
//   req_rom    out  one byte request per high cycle
//   blk_done   out  one-cycle pulse with the 16th request
//   rom_data   in   S-box output byte, valid ROM_LAT cycles after its request
//   o          out  assembled state; byte k is o[8k+7:8k], byte 0 first back
//   out_valid  out  o holds a complete block
//   out_ready  in   downstream accepts o
//   busy       out  high whenever not idle
//
// Output handshake: a block is transferred on a rising edge where
// out_valid && out_ready. out_valid stays high, and o stays stable, until that
// edge; out_valid never depends on out_ready, and out_ready is ignored while
// out_valid is low.
// -----------------------------------------------------------------------------
module mod_reg16_1to16 #(
   parameter int N       = 16,
   parameter int ROM_LAT = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           blk_valid,
   output logic           req_rom,
   output logic           blk_done,
   input  logic [7:0]     rom_data,
   output logic [8*N-1:0] o,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2,
      S_FULL  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         n_req_q, n_req_d;
   logic [4:0]         n_wr_q,  n_wr_d;
   logic [ROM_LAT-1:0] pipe_q,  pipe_d;
   logic [8*N-1:0]     o_q,     o_d;
   logic               tap;
   logic               capture;

   // The capture pipeline is a delayed copy of req_rom: its last stage is high
   // exactly in the cycle the ROM presents the byte for an earlier request.
   if (ROM_LAT == 1) begin : g_pipe_one
      assign pipe_d = req_rom;
   end else begin : g_pipe_many
      assign pipe_d = {pipe_q[ROM_LAT-2:0], req_rom};
   end

   assign tap = pipe_q[ROM_LAT-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_req_q <= '0;
         n_wr_q  <= '0;
         pipe_q  <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         n_req_q <= n_req_d;
         n_wr_q  <= n_wr_d;
         pipe_q  <= pipe_d;
         o_q     <= o_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      n_req_d   = n_req_q;
      n_wr_d    = n_wr_q;
      o_d       = o_q;
      req_rom   = 1'b0;
      blk_done  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;

      // Captures overlap the tail of REQ with DRAIN; the write counter
      // saturates at N so nothing can land past the last byte.
      capture = tap && ((state_q == S_REQ) || (state_q == S_DRAIN))
                && (n_wr_q < 5'(N));

      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (blk_valid) begin
               state_d = S_REQ;
               n_req_d = '0;
               n_wr_d  = '0;
            end
         end
         S_REQ: begin
            req_rom = 1'b1;
            if (n_req_q == 4'(N - 1)) begin
               blk_done = 1'b1;
               state_d  = S_DRAIN;
            end else begin
               n_req_d = n_req_q + 4'd1;
            end
         end
         S_DRAIN: begin
            // The last byte arrives ROM_LAT cycles after the last request,
            // so this state lasts exactly ROM_LAT cycles.
            if (capture && (n_wr_q == 5'(N - 1))) begin
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (capture) begin
         o_d[{n_wr_q[3:0], 3'b000} +: 8] = rom_data;
         n_wr_d = n_wr_q + 5'd1;
      end
   end

   assign o = o_q;

endmodule

// File: tb/tb_mod_reg16_1to16.sv
// -----------------------------------------------------------------------------
// tb_mod_reg16_1to16
//
// Two instances run side by side from the same control inputs: one with
// ROM_LAT=1 (index 0) and one with ROM_LAT=3 (index 1). The bench plays the
// serializer + S-box ROM for each, keeps a cycle-timeline model of what every
// output must be, and checks that model on every falling edge. Directed
// sequences add hand-computed literal expectations on top.
// -----------------------------------------------------------------------------
module tb_mod_reg16_1to16;

   logic         clk = 1'b0;
   logic         reset;
   logic         blk_valid;
   logic         out_ready;
   logic [7:0]   rom_data_w [2];
   logic         req_w      [2];
   logic         done_w     [2];
   logic         valid_w    [2];
   logic         busy_w     [2];
   logic [127:0] o_w        [2];

   int           n_checks = 0;
   int           n_errors = 0;
   logic         chk_en   = 1'b0;
   int           pat_sel  = 0;

   always #5 clk = ~clk;

   mod_reg16_1to16 #(.N(16), .ROM_LAT(1)) dut_l1 (
      .clk      (clk),
      .reset    (reset),
      .blk_valid(blk_valid),
      .req_rom  (req_w[0]),
      .blk_done (done_w[0]),
      .rom_data (rom_data_w[0]),
      .o        (o_w[0]),
      .out_valid(valid_w[0]),
      .out_ready(out_ready),
      .busy     (busy_w[0])
   );

   mod_reg16_1to16 #(.N(16), .ROM_LAT(3)) dut_l3 (
      .clk      (clk),
      .reset    (reset),
      .blk_valid(blk_valid),
      .req_rom  (req_w[1]),
      .blk_done (done_w[1]),
      .rom_data (rom_data_w[1]),
      .o        (o_w[1]),
      .out_valid(valid_w[1]),
      .out_ready(out_ready),
      .busy     (busy_w[1])
   );

   // ---------------------------------------------------------------- helpers
   function automatic int lat_of(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Pattern 0: AES S-box of input bytes 0x00..0x0F; pattern 1: 0xFF ^ index.
   function automatic logic [7:0] rom_byte(int pat, int k);
      logic [7:0] b;
      if (pat != 0) begin
         b = 8'hFF ^ 8'(k);
      end else begin
         case (k)
            0: b = 8'h63;  1: b = 8'h7C;  2: b = 8'h77;  3: b = 8'h7B;
            4: b = 8'hF2;  5: b = 8'h6B;  6: b = 8'h6F;  7: b = 8'hC5;
            8: b = 8'h30;  9: b = 8'h01; 10: b = 8'h67; 11: b = 8'h2B;
           12: b = 8'hFE; 13: b = 8'hD7; 14: b = 8'hAB; default: b = 8'h76;
         endcase
      end
      return b;
   endfunction

   function automatic logic [127:0] block_value(int pat);
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < 16; k++) v[8*k +: 8] = rom_byte(pat, k);
      return v;
   endfunction

   function automatic void chk_bit(string name, int d, logic act, logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s lat%0d: got %b expected %b (t=%0t)", name, lat_of(d), act, exp, $time);
      end
   endfunction

   function automatic void chk_vec(string name, int d, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s lat%0d: got %h expected %h (t=%0t)", name, lat_of(d), act, exp, $time);
      end
   endfunction

   function automatic void chk_int(string name, int d, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s lat%0d: got %0d expected %0d", name, lat_of(d), act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the held block (both instances assumed full) and idles a moment.
   task automatic drain();
      out_ready = 1'b1;
      blk_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      tick();
      tick();
   endtask

   // ------------------------------------------------ serializer + ROM model
   // A request seen in cycle c yields its byte on rom_data during cycle c+L.
   logic [7:0] rom_line [2][4];
   int         rom_idx  [2];
   logic [7:0] rom_nb;

   initial begin
      for (int d = 0; d < 2; d++) begin
         rom_idx[d]    = 0;
         rom_data_w[d] = 8'h00;
         for (int i = 0; i < 4; i++) rom_line[d][i] = 8'h00;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 3; i > 0; i--) rom_line[d][i] = rom_line[d][i-1];
         if (reset) begin
            rom_idx[d] = 0;
            rom_nb     = 8'h5A;
         end else if (req_w[d]) begin
            rom_nb     = rom_byte(pat_sel, rom_idx[d]);
            rom_idx[d] = (rom_idx[d] + 1) % 16;
         end else begin
            rom_nb = 8'h5A;
         end
         rom_line[d][0] = rom_nb;
         rom_data_w[d]  = rom_line[d][lat_of(d)];
      end
   end

   // ---------------------------------------------- timeline model + compare
   // m_t is the cycle number within the current block (0 = idle): requests
   // in cycles 1..16, blk_done in 16, block held from cycle 17+L until taken.
   int           m_t [2];
   logic [127:0] m_o [2];
   logic [127:0] exp_q0 [$];
   logic [127:0] exp_q1 [$];
   int           ft;

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_t[d] = 0;
         m_o[d] = '0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            ft = 17 + lat_of(d);
            chk_bit("req_rom",   d, req_w[d],   (m_t[d] >= 1) && (m_t[d] <= 16));
            chk_bit("blk_done",  d, done_w[d],  m_t[d] == 16);
            chk_bit("out_valid", d, valid_w[d], m_t[d] == ft);
            chk_bit("busy",      d, busy_w[d],  m_t[d] != 0);
            if ((m_t[d] == 0) || (m_t[d] == ft)) chk_vec("o", d, o_w[d], m_o[d]);

            if (reset) begin
               m_t[d] = 0;
               m_o[d] = '0;
               if (d == 0) exp_q0.delete(); else exp_q1.delete();
            end else if (m_t[d] == 0) begin
               if (blk_valid) begin
                  m_t[d] = 1;
                  if (d == 0) exp_q0.push_back(block_value(pat_sel));
                  else        exp_q1.push_back(block_value(pat_sel));
               end
            end else if (m_t[d] == ft) begin
               if (out_ready) m_t[d] = 0;
            end else begin
               m_t[d] = m_t[d] + 1;
               if (m_t[d] == ft) begin
                  if (d == 0 && exp_q0.size() > 0)      m_o[d] = exp_q0.pop_front();
                  else if (d == 1 && exp_q1.size() > 0) m_o[d] = exp_q1.pop_front();
               end
            end
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   int           first_req [2];
   int           last_req  [2];
   int           done_cnt  [2];
   int           done_cyc  [2];
   int           rise      [2];
   int           restart   [2];
   int           hi_cnt    [2];
   int           v_cnt     [2];
   int           v_rise    [2];
   logic         v_prev    [2];
   logic [127:0] snap      [2];

   initial begin
      reset     = 1'b1;
      blk_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset state
      for (int d = 0; d < 2; d++) begin
         chk_vec("reset_o",         d, o_w[d],     '0);
         chk_bit("reset_out_valid", d, valid_w[d], 1'b0);
         chk_bit("reset_busy",      d, busy_w[d],  1'b0);
         hi_cnt[d] = 0;
      end

      // Idle hold: nothing moves for 50 cycles without blk_valid
      for (int c = 1; c <= 50; c++) begin
         tick();
         for (int d = 0; d < 2; d++)
            if (req_w[d] || busy_w[d] || valid_w[d]) hi_cnt[d]++;
      end
      for (int d = 0; d < 2; d++) chk_int("idle_activity", d, hi_cnt[d], 0);

      // Basic block then backpressure; blk_valid held high throughout
      for (int d = 0; d < 2; d++) begin
         first_req[d] = -1; last_req[d] = -1; done_cnt[d] = 0;
         done_cyc[d]  = -1; rise[d]     = -1; restart[d]  = -1;
      end
      pat_sel   = 0;
      out_ready = 1'b0;
      blk_valid = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            if (c < 38) begin
               if (req_w[d]) begin
                  if (first_req[d] < 0) first_req[d] = c;
                  last_req[d] = c;
               end
               if (done_w[d]) begin
                  done_cnt[d]++;
                  done_cyc[d] = c;
               end
               if (valid_w[d] && rise[d] < 0) rise[d] = c;
            end else if (req_w[d] && restart[d] < 0) begin
               restart[d] = c;
            end
         end
         if (c == 30) begin
            snap[0] = o_w[0];
            snap[1] = o_w[1];
         end
         out_ready = (c == 38);
         blk_valid = (c < 40);
      end
      for (int d = 0; d < 2; d++) begin
         chk_int("first_req",    d, first_req[d], 1);
         chk_int("last_req",     d, last_req[d],  16);
         chk_int("done_pulses",  d, done_cnt[d],  1);
         chk_int("done_cycle",   d, done_cyc[d],  16);
         chk_int("req_restart",  d, restart[d],   40);
         chk_vec("basic_byte0",  d, 128'(snap[d][7:0]),     128'h63);
         chk_vec("basic_byte1",  d, 128'(snap[d][15:8]),    128'h7C);
         chk_vec("basic_byte15", d, 128'(snap[d][127:120]), 128'h76);
      end
      chk_int("valid_rise", 0, rise[0], 18);
      chk_int("valid_rise", 1, rise[1], 20);
      drain();

      // Reset in cycle 8 of REQ, then a fresh block
      pat_sel   = 0;
      blk_valid = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 9) begin
            for (int d = 0; d < 2; d++) begin
               chk_bit("rst_req_rom",   d, req_w[d],   1'b0);
               chk_bit("rst_blk_done",  d, done_w[d],  1'b0);
               chk_bit("rst_out_valid", d, valid_w[d], 1'b0);
               chk_bit("rst_busy",      d, busy_w[d],  1'b0);
               chk_vec("rst_o",         d, o_w[d],     '0);
            end
         end
         blk_valid = 1'b0;
         reset     = (c == 8);
      end
      pat_sel   = 1;
      blk_valid = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         blk_valid = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
         chk_bit("fresh_valid",  d, valid_w[d], 1'b1);
         chk_vec("fresh_byte0",  d, 128'(o_w[d][7:0]),     128'hFF);
         chk_vec("fresh_byte7",  d, 128'(o_w[d][63:56]),   128'hF8);
         chk_vec("fresh_byte15", d, 128'(o_w[d][127:120]), 128'hF0);
      end
      drain();

      // Back-to-back with out_ready tied high
      for (int d = 0; d < 2; d++) begin
         v_cnt[d] = 0; v_rise[d] = 0; v_prev[d] = 1'b0; snap[d] = '0;
      end
      pat_sel   = 0;
      out_ready = 1'b1;
      blk_valid = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            if (valid_w[d]) begin
               v_cnt[d]++;
               if (!v_prev[d]) begin
                  v_rise[d]++;
                  if (v_rise[d] == 2) snap[d] = o_w[d];
               end
            end
            v_prev[d] = valid_w[d];
         end
         pat_sel   = (c >= 17) ? 1 : 0;
         blk_valid = (c < 22);
      end
      for (int d = 0; d < 2; d++) begin
         chk_int("b2b_valid_cycles", d, v_cnt[d],  2);
         chk_int("b2b_valid_pulses", d, v_rise[d], 2);
         chk_vec("b2b_second_block", d, snap[d],   block_value(1));
      end

      out_ready = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
